// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Grants are bursts of up to MAX_BURST words; writes are held off while wfull is high.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ack,
    input  logic                 wfull,
    output logic                 winc,
    output logic [W-1:0]         wdata,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [15:0]          stall_cnt
);

    localparam int IDW = $clog2(N);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [3:0]     burst_cnt;
    logic           sel_req;
    logic [IDW-1:0] pick_id;
    logic           pick_vld;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign sel_req = req[grant_id];
    assign busy    = (state == GRANT);

    // Write port is purely combinational off the held grant; reset kills it at once.
    always_comb begin
        winc    = 1'b0;
        req_ack = '0;
        wdata   = '0;
        if (wrst_n && state == GRANT) begin
            winc    = sel_req & ~wfull;
            req_ack = {{(N-1){1'b0}}, winc} << grant_id;
            wdata   = req_data[int'(grant_id)*W +: W];
        end
    end

    // Search starts just past the previous grantee and wraps.
    always_comb begin
        pick_id  = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_vld && req[(int'(last_grant) + k) % N]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'((int'(last_grant) + k) % N);
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(N - 1);
            burst_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id  <= pick_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!sel_req) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end else if (wfull) begin
                        stall_cnt <= sat_inc16(stall_cnt);
                    end else begin
                        burst_cnt <= burst_cnt + 4'd1;
                        if (burst_cnt == BURST_LAST) begin
                            state      <= IDLE;
                            last_grant <= grant_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural requesters plus a small FIFO model
// supply stimulus; write and drain logs are compared against hand-derived sequences.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MAXB  = 4;
    localparam int DEPTH = 8;

    logic           wclk = 1'b0;
    logic           wrst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           wfull = 1'b0;
    logic           winc;
    logic [W-1:0]   wdata;
    logic           busy;
    logic [1:0]     grant_id;
    logic [15:0]    stall_cnt;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(MAXB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .req_ack(req_ack), .wfull(wfull), .winc(winc), .wdata(wdata),
        .busy(busy), .grant_id(grant_id), .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] words [N][32];
    int           len [N];
    int           pos [N];

    logic [W-1:0] wr_data [$];
    int           wr_gid [$];
    int           wr_cyc [$];
    logic [N-1:0] wr_ack [$];
    logic [W-1:0] rd_log [$];
    logic [W-1:0] fq [$];

    int cyc, ack_cnt, viol;
    bit use_fifo, rd_en, saw_full;

    logic         s_winc, s_busy, s_wfull;
    logic [W-1:0] s_wdata;
    logic [N-1:0] s_ack;
    logic [1:0]   s_gid;
    logic [15:0]  s_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < len[i]) begin
                req[i] = 1'b1;
                req_data[i*W +: W] = words[i][pos[i]];
            end else begin
                req[i] = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
        if (use_fifo) wfull = (fq.size() >= DEPTH);
    endtask

    task automatic set_words(input int i, input int n, input logic [W-1:0] first, input bit incr);
        for (int k = 0; k < n; k++) words[i][k] = incr ? first + W'(k) : first;
        len[i] = n;
        pos[i] = 0;
    endtask

    task automatic clear_logs();
        wr_data.delete(); wr_gid.delete(); wr_cyc.delete(); wr_ack.delete();
        rd_log.delete();
        cyc = 0; ack_cnt = 0; viol = 0; saw_full = 0;
    endtask

    // Sample mid-cycle, then let requesters and the FIFO model react just after the edge.
    task automatic cycle();
        @(negedge wclk);
        cyc++;
        s_winc = winc; s_wdata = wdata; s_ack = req_ack; s_busy = busy;
        s_gid = grant_id; s_stall = stall_cnt; s_wfull = wfull;
        if (s_winc && s_wfull) viol++;
        if (s_wfull) saw_full = 1;
        if (s_ack != '0) ack_cnt++;
        if (s_winc) begin
            wr_data.push_back(s_wdata);
            wr_gid.push_back(int'(s_gid));
            wr_cyc.push_back(cyc);
            wr_ack.push_back(s_ack);
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++) if (s_ack[i]) pos[i]++;
        if (use_fifo) begin
            if (rd_en && fq.size() > 0) rd_log.push_back(fq.pop_front());
            if (s_winc) fq.push_back(s_wdata);
        end
        drive();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end
        use_fifo = 0; rd_en = 0; wfull = 1'b0;
        fq.delete();
        drive();
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        clear_logs();
    endtask

    logic [W-1:0] exp_rd [16];

    initial begin
        // Reset state
        do_reset();
        cycle();
        chk("rst_winc", s_winc, 0);
        chk("rst_ack", s_ack, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_gid", s_gid, 0);
        chk("rst_stall", s_stall, 0);

        // Single requester, five words
        do_reset();
        set_words(0, 5, 8'h01, 1);
        drive();
        repeat (8) cycle();
        chk("single_nwr", wr_data.size(), 5);
        chk("single_nack", ack_cnt, 5);
        if (wr_data.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("single_data", wr_data[k], k + 1);
                chk("single_ack", wr_ack[k], 4'b0001);
            end
            for (int k = 1; k < 4; k++) chk("single_b2b", wr_cyc[k] - wr_cyc[k-1], 1);
            chk("single_bubble", wr_cyc[4] - wr_cyc[3], 2);
        end

        // Round-robin with all four requesting
        do_reset();
        for (int i = 0; i < N; i++) set_words(i, 20, 8'hA0 + W'(i), 0);
        drive();
        repeat (22) cycle();
        chk("rr_nwr", wr_data.size(), 17);
        if (wr_data.size() >= 17) begin
            for (int k = 0; k < 17; k++) begin
                chk("rr_gid", wr_gid[k], (k / 4) % 4);
                chk("rr_data", wr_data[k], 8'hA0 + (k / 4) % 4);
            end
            chk("rr_b2b", wr_cyc[1] - wr_cyc[0], 1);
            for (int g = 1; g < 5; g++) chk("rr_gap", wr_cyc[4*g] - wr_cyc[4*g-1], 2);
        end

        // Full stall mid-burst on requester 2
        do_reset();
        set_words(2, 4, 8'h31, 1);
        drive();
        repeat (3) cycle();
        chk("stall_pre_nwr", wr_data.size(), 2);
        wfull = 1'b1;
        repeat (5) cycle();
        chk("stall_nwr", wr_data.size(), 2);
        chk("stall_nack", ack_cnt, 2);
        chk("stall_busy", s_busy, 1);
        chk("stall_gid", s_gid, 2);
        wfull = 1'b0;
        cycle();
        chk("stall_cnt", s_stall, 5);
        repeat (3) cycle();
        chk("stall_post_nwr", wr_data.size(), 4);
        if (wr_data.size() == 4)
            for (int k = 0; k < 4; k++) chk("stall_data", wr_data[k], 8'h31 + k);
        chk("stall_cnt_hold", s_stall, 5);

        // Early release by requester 1, requester 3 next, then 0
        do_reset();
        set_words(1, 2, 8'h41, 1);
        set_words(3, 1, 8'h61, 1);
        drive();
        repeat (3) cycle();
        set_words(0, 1, 8'h51, 1);
        drive();
        cycle();
        chk("rel_drop_busy", s_busy, 1);
        chk("rel_drop_winc", s_winc, 0);
        cycle();
        chk("rel_idle_busy", s_busy, 0);
        chk("rel_idle_gid", s_gid, 1);
        cycle();
        chk("rel_next_busy", s_busy, 1);
        chk("rel_next_gid", s_gid, 3);
        repeat (4) cycle();
        chk("rel_nwr", wr_data.size(), 4);
        if (wr_data.size() == 4) begin
            chk("rel_g0", wr_gid[0], 1); chk("rel_d0", wr_data[0], 8'h41);
            chk("rel_g1", wr_gid[1], 1); chk("rel_d1", wr_data[1], 8'h42);
            chk("rel_g2", wr_gid[2], 3); chk("rel_d2", wr_data[2], 8'h61);
            chk("rel_g3", wr_gid[3], 0); chk("rel_d3", wr_data[3], 8'h51);
        end

        // Asynchronous reset during the third write
        do_reset();
        set_words(2, 4, 8'h71, 1);
        drive();
        repeat (2) cycle();
        wfull = 1'b1;
        cycle();
        wfull = 1'b0;
        cycle();
        @(negedge wclk);
        chk("mrst_pre_winc", winc, 1);
        chk("mrst_pre_wdata", wdata, 8'h73);
        chk("mrst_pre_stall", stall_cnt, 1);
        wrst_n = 1'b0;
        #1;
        chk("mrst_winc", winc, 0);
        chk("mrst_ack", req_ack, 0);
        chk("mrst_wdata", wdata, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_gid", grant_id, 0);
        chk("mrst_stall", stall_cnt, 0);
        for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end
        set_words(0, 1, 8'h81, 1);
        set_words(1, 1, 8'h91, 1);
        drive();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        clear_logs();
        cycle();
        chk("mrst_post_busy", s_busy, 0);
        repeat (5) cycle();
        chk("mrst_nwr", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            chk("mrst_first_gid", wr_gid[0], 0); chk("mrst_first_d", wr_data[0], 8'h81);
            chk("mrst_second_gid", wr_gid[1], 1); chk("mrst_second_d", wr_data[1], 8'h91);
        end

        // End-to-end against a depth-8 FIFO model
        do_reset();
        use_fifo = 1;
        set_words(0, 8, 8'h10, 1);
        set_words(1, 8, 8'h20, 1);
        drive();
        repeat (14) cycle();
        chk("e2e_full", s_wfull, 1);
        chk("e2e_fill", fq.size(), 8);
        chk("e2e_nwr_fill", wr_data.size(), 8);
        rd_en = 1;
        repeat (40) cycle();
        for (int k = 0; k < 4; k++) begin
            exp_rd[k]      = 8'h10 + W'(k);
            exp_rd[k + 4]  = 8'h20 + W'(k);
            exp_rd[k + 8]  = 8'h14 + W'(k);
            exp_rd[k + 12] = 8'h24 + W'(k);
        end
        chk("e2e_nwr", wr_data.size(), 16);
        chk("e2e_nrd", rd_log.size(), 16);
        if (rd_log.size() == 16)
            for (int k = 0; k < 16; k++) chk("e2e_order", rd_log[k], exp_rd[k]);
        chk("e2e_overflow", viol, 0);
        chk("e2e_saw_full", saw_full, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter in front of the async `fifo`, sharing its single write port (`winc`/`wdata`/`wfull`, `wclk` domain) among N requesters. Each requester presents words with a req/ack handshake; the arbiter grants one requester at a time for a burst of up to MAX_BURST words, never writes while `wfull` is high, and counts full-stall cycles. It sits entirely in the write-clock domain; the read side of `fifo` is untouched.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- W, 8: data width, matches `fifo` wdata.
- MAX_BURST, 4: max words written per grant (1..15).

Ports:
- wclk  in  1  write-domain clock; all logic on rising edge.
- wrst_n  in  1  reset; asynchronous, active-low.
- req  in  N  requester i has a valid word on its data slice.
- req_data  in  N*W  requester i's word at bits [i*W +: W].
- req_ack  out  N  one-hot; bit i high = requester i's word written this cycle.
- wfull  in  1  FIFO full flag, from `fifo` wfull.
- winc  out  1  FIFO write enable, to `fifo` winc.
- wdata  out  W  FIFO write data, to `fifo` wdata.
- busy  out  1  arbiter is in GRANT.
- grant_id  out  clog2(N)  index of the current or most recent grantee.
- stall_cnt  out  16  saturating count of full-stall cycles.

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, last_grant, burst_cnt (4 bits), stall_cnt.
- Reset values: state=IDLE, grant_id=0, last_grant=N-1, burst_cnt=0, stall_cnt=0. Outputs during reset: winc=0, req_ack=0, wdata=0, busy=0.
- IDLE: if any req bit is set, pick the first set bit searching from (last_grant+1) mod N upward with wrap. Register grant_id, clear burst_cnt, go to GRANT. With no req, stay in IDLE.
- GRANT, combinational outputs:
  - winc = req[grant_id] & ~wfull.
  - req_ack = winc << grant_id.
  - wdata = req_data slice of grant_id.
- IDLE outputs: wdata=0, winc=0, req_ack=0.
- GRANT, on each write (winc=1): burst_cnt increments.
- GRANT exit: on the edge where burst_cnt reaches MAX_BURST, or on any cycle with req[grant_id]=0, go to IDLE and set last_grant <= grant_id. This applies even if zero words were written.
- Full stall: in GRANT with req[grant_id]=1 and wfull=1, no write occurs, the grant is held, and stall_cnt increments, saturating at 0xFFFF.
- Requester protocol: hold req and data stable until ack. A requester may present a new word in the cycle after ack or drop req. Dropping req without an ack is legal and discards nothing.
- Asserting wrst_n low at any time forces IDLE and drives winc=0 immediately, asynchronously. No partial write is issued.

## Timing
- Arbitration latency: req seen in IDLE at edge k gives the first possible write in cycle k+1.
- Back-to-back writes within a burst: one word per cycle while req is held and wfull=0.
- Exactly one IDLE bubble cycle between consecutive grants.
- wfull is sampled combinationally in the same cycle as winc. A write that sets wfull stops the next cycle's write, with no overflow.
- Simultaneous requests resolve by round-robin order only. There is no fixed priority after the first arbitration, where requester 0 wins from reset.
- req deasserting in the same cycle that burst_cnt would reach MAX_BURST: no write occurs; exit is via the req-drop rule.
- Arbitration keys on req only, never on wfull: a requester can hold the grant while the FIFO is full.

## Test plan
- Single requester: req[0]=1 after reset with data 1,2,3,4,5 (new word after each ack), wfull=0. Required:
  - Writes 1,2,3,4 on consecutive cycles, then one bubble, then 5.
  - req_ack[0] pulses align with winc.
- Round-robin: req=4'b1111 held, each requester sends a constant word 0xA0+i. Required:
  - Grant order 0,1,2,3,0.
  - Four 0xA0+i words per grant.
  - One idle cycle between grants.
- Full stall: grant requester 2; wfull=1 for 5 cycles mid-burst. Required:
  - winc=0 and req_ack=0 for those 5 cycles.
  - stall_cnt=5.
  - Burst resumes without losing or duplicating a word.
- Early release: requester 1 drops req after 2 words while req[3]=1. Required:
  - Next cycle IDLE, then grant_id=3.
  - last_grant=1.
- Reset mid-burst: pull wrst_n low during the third write cycle. Required:
  - winc drops immediately.
  - All registers return to reset values.
  - After release with req[1]=1 and req[0]=1, requester 0 is granted first.
- End-to-end with `fifo`: two requesters push 16 words total with read disabled. Required:
  - wfull asserts and winc never coincides with wfull=1.
  - A subsequent drain returns words in grant order.
